// File: rtl/mem_stage.sv
// mem_stage: data-memory access stage with req/ack bus FSM, lane alignment and the MEM/WB register.
module mem_stage #(
  parameter int ACK_TIMEOUT = 16,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [1:0]  i_mem_size,
  input  logic        i_mem_signed,
  input  logic        i_flush,
  input  logic        i_reg_write,
  input  logic [4:0]  i_reg_dest,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_store_data,
  input  logic        i_dm_ack,
  input  logic [31:0] i_dm_rdata,
  output logic        o_dm_req,
  output logic        o_dm_we,
  output logic [31:0] o_dm_addr,
  output logic [3:0]  o_dm_byte_en,
  output logic [31:0] o_dm_wdata,
  output logic        o_stall,
  output logic        o_fault,
  output logic [31:0] o_fw_from_mem,
  output logic        o_wb_reg_write,
  output logic        o_wb_mem_to_reg,
  output logic [4:0]  o_wb_reg_dest,
  output logic [31:0] o_wb_alu_result,
  output logic [31:0] o_wb_read_data
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  localparam int CW = $clog2(ACK_TIMEOUT + 2);
  state_t      r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic        r_abort, r_fault, r_we, r_sign;
  logic [1:0]  r_size, r_off;
  logic [3:0]  r_be;
  logic [31:0] r_addr, r_wdata, r_ldbuf;
  logic        r_wb_rw, r_wb_m2r;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_alu, r_wb_rdata;
  logic        w_op, w_word, w_half, w_mis, w_start, w_timeout, w_stall;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_sh, w_load;
  assign w_op      = (i_mem_read | i_mem_write) & ~i_flush;
  assign w_word    = (i_mem_size == 2'b00) | (i_mem_size == 2'b11);
  assign w_half    = i_mem_size == 2'b01;
  assign w_mis     = CHECK_ALIGN && ((w_word && i_alu_result[1:0] != 2'b00) || (w_half && i_alu_result[0]));
  assign w_start   = (r_state == IDLE) & w_op & ~w_mis;
  assign w_timeout = (ACK_TIMEOUT != 0) && (r_cnt == CW'(ACK_TIMEOUT - 1));
  assign w_be      = w_word ? 4'hF : w_half ? (i_alu_result[1] ? 4'hC : 4'h3) : 4'b0001 << i_alu_result[1:0];
  assign w_wdata   = w_word ? i_store_data : w_half ? {2{i_store_data[15:0]}} : {4{i_store_data[7:0]}};
  // Shifting by the captured byte offset puts the addressed lane at bit 0 for both byte and half loads.
  assign w_sh      = i_dm_rdata >> {r_off, 3'b000};
  assign w_load    = r_size == 2'b10 ? {{24{r_sign & w_sh[7]}}, w_sh[7:0]} :
                     r_size == 2'b01 ? {{16{r_sign & w_sh[15]}}, w_sh[15:0]} : i_dm_rdata;
  always_comb begin
    w_next  = r_state == IDLE ? (w_start ? WAIT : IDLE) :
              r_state == WAIT ? ((i_dm_ack | w_timeout) ? DONE : WAIT) : IDLE;
    w_stall = i_rst_n & (w_start | (r_state == WAIT));
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_abort    <= 1'b0;
      r_fault    <= 1'b0;
      r_we       <= 1'b0;
      r_sign     <= 1'b0;
      r_size     <= 2'b00;
      r_off      <= 2'b00;
      r_be       <= 4'h0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_ldbuf    <= '0;
      r_wb_rw    <= 1'b0;
      r_wb_m2r   <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_alu   <= '0;
      r_wb_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= r_state == WAIT ? r_cnt + 1'b1 : '0;
      r_fault <= ((r_state == IDLE) & w_op & w_mis) | ((r_state == WAIT) & ~i_dm_ack & w_timeout);
      r_abort <= (r_state == WAIT) & ~i_dm_ack & w_timeout;
      if (w_start) begin
        r_addr  <= {i_alu_result[31:2], 2'b00};
        r_off   <= i_alu_result[1:0];
        r_be    <= w_be;
        r_wdata <= w_wdata;
        r_we    <= i_mem_write;
        r_size  <= i_mem_size;
        r_sign  <= i_mem_signed;
      end
      if ((r_state == WAIT) & i_dm_ack) r_ldbuf <= w_load;
      if (w_stall) begin
        r_wb_rw  <= 1'b0;
        r_wb_m2r <= 1'b0;
      end else begin
        r_wb_rw    <= i_reg_write & ~i_flush & ~(w_op & w_mis) & ~r_abort;
        r_wb_m2r   <= i_mem_read;
        r_wb_rd    <= i_reg_dest;
        r_wb_alu   <= i_alu_result;
        r_wb_rdata <= r_ldbuf;
      end
    end
  end
  assign o_dm_req        = r_state == WAIT;
  assign o_dm_we         = r_we;
  assign o_dm_addr       = r_addr;
  assign o_dm_byte_en    = r_be;
  assign o_dm_wdata      = r_wdata;
  assign o_stall         = w_stall;
  assign o_fault         = r_fault;
  assign o_fw_from_mem   = i_alu_result;
  assign o_wb_reg_write  = r_wb_rw;
  assign o_wb_mem_to_reg = r_wb_m2r;
  assign o_wb_reg_dest   = r_wb_rd;
  assign o_wb_alu_result = r_wb_alu;
  assign o_wb_read_data  = r_wb_rdata;
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access stage directly downstream of the execute stage. It consumes the ALU result, the forwarded store operand, the destination register and the RegWrite qualifier, and runs loads and stores against an external data-memory bus that uses a variable-latency req/ack handshake. It aligns store data and byte enables, extracts and extends load data, and stalls the pipeline while a bus access is pending. It also owns the MEM/WB pipeline register that feeds write-back and the WB forwarding path.

Parameters:
ACK_TIMEOUT, 16, maximum number of WAIT cycles without DM_Ack before the access is aborted; 0 disables the timeout.
CHECK_ALIGN, 1, when 1, misaligned word and half accesses raise a fault instead of issuing a bus request.

Ports:
Clock  in  1  single clock; every register updates on the rising edge.
Reset  in  1  synchronous, active-low reset.
MemRead  in  1  load in MEM.
MemWrite  in  1  store in MEM.
MemSize  in  2  00 word, 01 half, 10 byte, 11 illegal (treated as word).
MemSigned  in  1  1 = sign-extend the load result, 0 = zero-extend.
Flush  in  1  squash the op currently in MEM.
RegWrite_In  in  1  RegWrite from execute.
RegDest_In  in  5  destination register from execute.
ALUResult  in  32  effective address, or non-memory result.
StoreData  in  32  forwarded rt value.
DM_Ack  in  1  bus acknowledge.
DM_RData  in  32  bus read data, valid when DM_Ack=1.
DM_Req  out  1  bus request.
DM_We  out  1  bus write strobe.
DM_Addr  out  32  word address, bits [1:0] forced to 0.
DM_ByteEn  out  4  lane enables.
DM_WData  out  32  lane-replicated store data.
Stall  out  1  hold IF, ID and EX.
Fault  out  1  one-cycle pulse on a misaligned access or a bus timeout.
FWFromMEM  out  32  combinational copy of ALUResult.
WB_RegWrite  out  1  MEM/WB register.
WB_MemToReg  out  1  MEM/WB register.
WB_RegDest  out  5  MEM/WB register.
WB_ALUResult  out  32  MEM/WB register.
WB_ReadData  out  32  MEM/WB register.

Behaviour:
- Reset (Reset=0 at a rising edge):
  - State goes to IDLE; the timeout counter clears.
  - DM_Req, DM_We, DM_ByteEn, DM_Addr, DM_WData, Fault and all WB_* outputs go to 0.
  - Stall is 0 in the cycle after reset.
  - A reset in the middle of an access abandons it: DM_Req drops on that edge and any late DM_Ack is ignored.
- Access op: Op = (MemRead|MemWrite) & ~Flush. If both MemRead and MemWrite are high, the access is treated as a write.
- Misalignment check (CHECK_ALIGN=1):
  - Word with addr[1:0]≠0, or half with addr[0]≠0, is misaligned.
  - A misaligned op issues no request and raises no Stall.
  - Fault pulses in the next cycle.
  - The MEM/WB load that edge is written with WB_RegWrite=0.
- Lane rules (little-endian):
  - Word: ByteEn=1111, WData=StoreData.
  - Half: ByteEn=0011 when addr[1]=0, else 1100; WData={2{StoreData[15:0]}}.
  - Byte: ByteEn = 0001 << addr[1:0]; WData={4{StoreData[7:0]}}.
- Load extraction: select the lane from the captured address, then sign- or zero-extend per MemSigned.
- FSM IDLE:
  - On an aligned Op: Stall=1 (combinational). Capture address, ByteEn, WData, We and size/sign into bus registers. Go to WAIT.
  - Otherwise Stall=0.
- FSM WAIT:
  - DM_Req=1; bus fields are held stable; Stall=1; the timeout counter increments.
  - DM_Ack=1: capture the extracted load into the load buffer, go to DONE, DM_Req drops on that edge.
  - Count reaches ACK_TIMEOUT with no ack: go to DONE with the abort flag set; Fault pulses.
  - Flush is ignored while in WAIT.
- FSM DONE:
  - Stall=0; go to IDLE next edge.
  - The instruction is still presented on the inputs but must not re-trigger an access.
- Minimum memory-op latency: 2 stall cycles (IDLE, then WAIT with an immediate ack). The MEM/WB register loads on the DONE edge.
- MEM/WB register on each edge:
  - Stall=1: insert a bubble (WB_RegWrite=0, WB_MemToReg=0, other WB_* fields hold).
  - Stall=0:
    - WB_RegWrite <= RegWrite_In & ~Flush & ~misaligned & ~aborted load.
    - WB_MemToReg <= MemRead.
    - WB_RegDest, WB_ALUResult <= inputs.
    - WB_ReadData <= load buffer.
- Non-memory ops pass through the MEM/WB register in one cycle with no stall.

Test Plan:
- Reset=0 for 2 cycles while MemRead=1 → all outputs are 0 and no DM_Req is issued. Release reset, then LW addr 0x100 with ack on the first WAIT cycle → Stall high for 2 cycles; DM_Addr=0x100, ByteEn=1111; WB_ReadData=DM_RData, WB_MemToReg=1, WB_RegWrite=1.
- LB signed at addr 0x203, DM_RData=0x80FF_1234 → ByteEn=1000 and WB_ReadData=0xFFFF_FF80. The same access with LBU → 0x0000_0080.
- SH at addr 0x0E, StoreData=0xAAAA_BEEF → DM_We=1, ByteEn=1100, DM_WData=0xBEEF_BEEF, DM_Addr=0x0C, WB_RegWrite=0.
- LW at addr 0x102 → no DM_Req and Stall stays 0; Fault pulses 1 cycle later; WB_RegWrite=0.
- LW with DM_Ack withheld and ACK_TIMEOUT=4 → Stall lasts 5 cycles; Fault pulses; the DONE-edge MEM/WB load has WB_RegWrite=0. Repeat the access and drop Reset on WAIT cycle 2 → DM_Req=0 and state is IDLE at the next edge.
- Back-to-back ADD (RegWrite=1, RegDest=5, ALUResult=7), then Flush asserted with a LW → ADD reaches WB_* in 1 cycle with no stall; the flushed LW issues no request and has WB_RegWrite=0.
